mem_access_unit: RTL and testbench

- Sits directly upstream of the data memory. Accepts one load/store request at a time from the CPU datapath and performs byte and halfword lane alignment.
- Sub-word stores are done as read-modify-write, because the memory is driven in word mode only.
- Returns sign- or zero-extended load data with a one-cycle done pulse, and flags misaligned accesses.

---
 rtl/mau_pkg.sv | 24 ++
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mau_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared size codes, state encoding and alignment helper for mem_access_unit
package mau_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Word needs both low bits clear, half needs bit 0 clear; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_WORD && addr_lo != 2'b00) mis = 1'b1;
        if (size == SZ_HALF && addr_lo[0])       mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU request/response and data-memory bus for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    // CPU side
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              addr_err;
    logic              busy;
    // Data memory side
    logic              dm_ena;
    logic              dm_wena;
    logic [1:0]        dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    // Environment: drives requests and supplies memory read data
    modport master (
        output req, we, size, sign_ext, addr, wdata, dm_rdata,
        input  rdata, done, addr_err, busy, dm_ena, dm_wena, dm_size, dm_addr, dm_wdata
    );

    // The access unit itself
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, dm_rdata,
        output rdata, done, addr_err, busy, dm_ena, dm_wena, dm_size, dm_addr, dm_wdata
    );
endinterface

// File: rtl/mau_lane_align.sv
// rtl/mau_lane_align.sv - little-endian lane extraction/extension for loads and lane merge for stores
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane, extend it for loads and splice store data into the word
    always_comb begin
        shifted = word_i >> {addr_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        store_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{sign_ext_i & byte_v[7]}}, byte_v};
                store_o = word_i;
                store_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{sign_ext_i & half_v[15]}}, half_v};
                store_o = word_i;
                store_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                store_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-request load/store unit with lane alignment and sub-word read-modify-write
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int CHECK_ALIGN = 1,
    parameter int ADDR_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    state_t            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              addr_err_q;

    logic [1:0]        size_d;
    logic [ADDR_W-1:0] addr_d;
    logic              misaligned;
    logic [31:0]       align_word;
    logic [31:0]       load_ext;
    logic [31:0]       store_word;

    // Normalise the incoming request: size 11 is a word, and without alignment checking the
    // offending low address bits are simply dropped.
    always_comb begin
        size_d     = (bus.size == 2'b11) ? SZ_WORD : bus.size;
        misaligned = is_misaligned(size_d, bus.addr[1:0]);
        addr_d     = bus.addr;
        if (CHECK_ALIGN == 0) begin
            if (size_d == SZ_WORD) addr_d[1:0] = 2'b00;
            if (size_d == SZ_HALF) addr_d[0]   = 1'b0;
        end
    end

    // In READ the load result is formed straight from memory so rdata is ready in DONE
    assign align_word = (state_q == READ) ? bus.dm_rdata : word_q;

    mau_lane_align u_lane_align (
        .word_i     (align_word),
        .addr_i     (addr_q[1:0]),
        .size_i     (size_q),
        .sign_ext_i (sign_ext_q),
        .wdata_i    (wdata_q),
        .load_o     (load_ext),
        .store_o    (store_word)
    );

    // Request FSM: latch in IDLE, read in READ, write in WRITE, report in DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_WORD;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q       <= bus.we;
                        size_q     <= size_d;
                        sign_ext_q <= bus.sign_ext;
                        addr_q     <= addr_d;
                        wdata_q    <= bus.wdata;
                        if ((CHECK_ALIGN != 0) && misaligned) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            addr_err_q <= 1'b1;
                        end else if (!bus.we || size_d != SZ_WORD) begin
                            state_q <= READ;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end
                READ: begin
                    word_q <= bus.dm_rdata;
                    if (!we_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= load_ext;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.done     = done_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.dm_ena   = (state_q == READ) || (state_q == WRITE);
    assign bus.dm_wena  = (state_q == WRITE);
    assign bus.dm_size  = SZ_WORD;
    assign bus.dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.dm_wdata = (state_q == WRITE) ? store_word : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mau_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pre = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.CHECK_ALIGN(1), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Word-mode data memory: combinational read, write on rising edge
    logic [31:0] mem [0:63];
    assign bus.dm_rdata = mem[bus.dm_addr[7:2]];

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h1122_3344;
            mem[4] <= 32'h80FF_7F01;
            mem[8] <= 32'hBEEF_1234;
        end else if (bus.dm_ena && bus.dm_wena) begin
            mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle N+1
    task automatic start(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.we       = we;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.req      = 1'b1;
        step();
        bus.req      = 1'b0;
    endtask

    // Walk until done (bounded); lat is the cycle offset from N at which done is seen
    task automatic wait_done(output int lat, output int wcnt, output int wlat,
                             output logic [31:0] wd, output logic ena_seen);
        lat = 1; wcnt = 0; wlat = 0; wd = 32'h0; ena_seen = 1'b0;
        while (!bus.done && lat < 10) begin
            if (bus.dm_ena) ena_seen = 1'b1;
            if (bus.dm_wena) begin
                wcnt++;
                wlat = lat;
                wd = bus.dm_wdata;
            end
            step();
            lat++;
        end
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] exp);
        int lat, wcnt, wlat;
        logic [31:0] wd;
        logic ena;
        start(1'b0, sz, sx, a, 32'h0);
        wait_done(lat, wcnt, wlat, wd, ena);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_err"}, 32'(bus.addr_err), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, exp);
        chk({tag, "_wcnt"}, 32'(wcnt), 32'd0);
        step();
    endtask

    int lat, wcnt, wlat, dcnt;
    logic [31:0] wd;
    logic ena;

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        pre = 1'b0;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.addr_err), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_ena", 32'(bus.dm_ena), 32'd0);
        chk("rst_wena", 32'(bus.dm_wena), 32'd0);
        reset = 1'b1;
        step();

        load("lb13", SZ_BYTE, 1'b1, 32'h13, 32'hFFFF_FF80);
        load("lbu13", SZ_BYTE, 1'b0, 32'h13, 32'h0000_0080);
        load("lh22", SZ_HALF, 1'b1, 32'h22, 32'hFFFF_BEEF);
        load("lhu20", SZ_HALF, 1'b0, 32'h20, 32'h0000_1234);
        load("lb10", SZ_BYTE, 1'b1, 32'h10, 32'h0000_0001);
        load("lw11_sz3", 2'b11, 1'b1, 32'h10, 32'h80FF_7F01);

        // sb read-modify-write
        start(1'b1, SZ_BYTE, 1'b0, 32'h09, 32'h0000_00AA);
        wait_done(lat, wcnt, wlat, wd, ena);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_wcnt", 32'(wcnt), 32'd1);
        chk("sb_wlat", 32'(wlat), 32'd2);
        chk("sb_wdata", wd, 32'h1122_AA44);
        chk("sb_err", 32'(bus.addr_err), 32'd0);
        chk("sb_rdata_kept", bus.rdata, 32'h80FF_7F01);
        step();
        load("lw08", SZ_WORD, 1'b0, 32'h08, 32'h1122_AA44);

        // sh read-modify-write, upper lane
        start(1'b1, SZ_HALF, 1'b0, 32'h0A, 32'hFFFF_5566);
        wait_done(lat, wcnt, wlat, wd, ena);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_wdata", wd, 32'h5566_AA44);
        step();

        // Misaligned word load
        start(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0);
        wait_done(lat, wcnt, wlat, wd, ena);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(bus.addr_err), 32'd1);
        chk("mis_ena", 32'(ena | bus.dm_ena), 32'd0);
        chk("mis_rdata", bus.rdata, 32'h1122_AA44);
        step();
        chk("mis_err_clr", 32'(bus.addr_err), 32'd0);

        // Word store with a req pulsed while busy
        start(1'b1, SZ_WORD, 1'b0, 32'h00, 32'hDEAD_BEEF);
        chk("sw_busy", 32'(bus.busy), 32'd1);
        chk("sw_wena", 32'(bus.dm_wena), 32'd1);
        bus.we = 1'b0; bus.addr = 32'h10; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        chk("sw_done", 32'(bus.done), 32'd1);
        step();
        chk("ignored_busy", 32'(bus.busy), 32'd0);
        chk("sw_mem", mem[0], 32'hDEAD_BEEF);
        load("lw00", SZ_WORD, 1'b0, 32'h00, 32'hDEAD_BEEF);

        // Reset during READ of a half store
        start(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_5678);
        chk("rmo_busy", 32'(bus.busy), 32'd1);
        chk("rmo_wena", 32'(bus.dm_wena), 32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rmo_idle", 32'(bus.busy), 32'd0);
        chk("rmo_done", 32'(bus.done), 32'd0);
        chk("rmo_rdata", bus.rdata, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done || bus.dm_wena) dcnt++;
            step();
        end
        chk("rmo_quiet", 32'(dcnt), 32'd0);
        chk("rmo_mem", mem[8], 32'hBEEF_1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
